fifo_rd_packer: RTL and testbench

Read-side consumer for the asynchronous byte FIFO, running entirely in the read clock domain. Pops DATA_WIDTH-bit entries whenever the FIFO is non-empty and packs BYTES_PER_WORD consecutive entries, little-endian, into one wide word. Each word is presented on a valid/ready output port. A flush request emits a trailing partial word with a lane-keep mask.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_out_reg.sv | 56 +++++
 rtl/fifo_rd_packer.sv | 133 +++++++++++++
 tb/tb_fifo_rd_packer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the read-side FIFO packer: default entry width,
// packer FSM states and the accepted-word counter width.
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int WCNT_W         = 16;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    EMIT  = 2'd2
  } state_t;
endpackage

// File: rtl/fifo_out_reg.sv
// Single-entry valid/ready output register: holds its word while stalled
// and counts words accepted downstream.
module fifo_out_reg
  import fifo_pkg::*;
#(
  parameter int OUT_WIDTH  = 32,
  parameter int KEEP_WIDTH = 4,
  parameter int CNT_W      = WCNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [OUT_WIDTH-1:0]  i_data,
  input  logic [KEEP_WIDTH-1:0] i_keep,
  input  logic                  i_ready,
  output logic [OUT_WIDTH-1:0]  o_data,
  output logic [KEEP_WIDTH-1:0] o_keep,
  output logic                  o_valid,
  output logic                  o_free,
  output logic [CNT_W-1:0]      o_word_cnt
);
  logic [OUT_WIDTH-1:0]  r_data;
  logic [KEEP_WIDTH-1:0] r_keep;
  logic                  r_valid;
  logic [CNT_W-1:0]      r_word_cnt;
  logic                  w_accept;

  assign w_accept = r_valid && i_ready;
  // The slot can take a new word on the same edge its current word leaves.
  assign o_free   = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_keep     <= '0;
      r_valid    <= 1'b0;
      r_word_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
      end
      if (i_load) begin
        r_data  <= i_data;
        r_keep  <= i_keep;
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data     = r_data;
  assign o_keep     = r_keep;
  assign o_valid    = r_valid;
  assign o_word_cnt = r_word_cnt;
endmodule

// File: rtl/fifo_rd_packer.sv
// Pops FIFO entries and packs BYTES_PER_WORD of them little-endian into one
// output word; a flush request emits the buffered partial word with a keep mask.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                                 rdclk,
  input  logic                                 rdrst_n,
  input  logic                                 fifo_empty,
  input  logic [DATA_WIDTH-1:0]                fifo_rdata,
  output logic                                 rd_en,
  input  logic                                 flush,
  output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] m_data,
  output logic [BYTES_PER_WORD-1:0]            m_keep,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic                                 flush_done,
  output logic [WCNT_W-1:0]                    word_cnt
);
  localparam int OUT_WIDTH = DATA_WIDTH * BYTES_PER_WORD;
  localparam int FCW       = $clog2(BYTES_PER_WORD + 1);
  localparam logic [FCW-1:0] FILL_FULL = FCW'(BYTES_PER_WORD);
  localparam logic [FCW-1:0] FILL_LAST = FCW'(BYTES_PER_WORD - 1);

  state_t                r_state, w_state_next;
  logic [FCW-1:0]        r_fill_cnt;
  logic                  r_rd_pending;
  logic                  r_flush_done, w_flush_done_next;
  logic [DATA_WIDTH-1:0] r_pack [BYTES_PER_WORD];

  logic                      w_out_free, w_full_ready, w_load_full, w_load_partial, w_load;
  logic [FCW:0]              w_inflight;
  logic [OUT_WIDTH-1:0]      w_full_word, w_part_word, w_load_data;
  logic [BYTES_PER_WORD-1:0] w_part_keep, w_load_keep;

  assign w_inflight   = {1'b0, r_fill_cnt} + {{FCW{1'b0}}, r_rd_pending};
  // A word is complete either parked in the pack register or arriving now in the last lane.
  assign w_full_ready = (r_fill_cnt == FILL_FULL) || (r_rd_pending && (r_fill_cnt == FILL_LAST));
  assign w_load_full    = w_full_ready && w_out_free;
  assign w_load_partial = (r_state == EMIT) && w_out_free;
  assign w_load         = w_load_full || w_load_partial;

  assign rd_en = rdrst_n && !fifo_empty && (r_state == FILL) &&
                 ((w_inflight < (FCW + 1)'(BYTES_PER_WORD)) ||
                  (r_rd_pending && (r_fill_cnt == FILL_LAST) && w_out_free));

  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      always_ff @(posedge rdclk) begin
        if (!rdrst_n) begin
          r_pack[gi] <= '0;
        end else if (r_rd_pending && (r_fill_cnt == FCW'(gi))) begin
          r_pack[gi] <= fifo_rdata;
        end
      end

      assign w_full_word[gi*DATA_WIDTH +: DATA_WIDTH] =
        (r_rd_pending && (r_fill_cnt == FCW'(gi))) ? fifo_rdata : r_pack[gi];
      assign w_part_keep[gi] = (r_fill_cnt > FCW'(gi));
      assign w_part_word[gi*DATA_WIDTH +: DATA_WIDTH] = w_part_keep[gi] ? r_pack[gi] : '0;
    end
  endgenerate

  assign w_load_data = w_load_full ? w_full_word : w_part_word;
  assign w_load_keep = w_load_full ? {BYTES_PER_WORD{1'b1}} : w_part_keep;

  always_comb begin
    w_state_next      = r_state;
    w_flush_done_next = 1'b0;
    case (r_state)
      FILL: begin
        if (flush) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (!r_rd_pending && !w_full_ready) begin
          if (r_fill_cnt == '0) begin
            w_state_next      = FILL;
            w_flush_done_next = 1'b1;
          end else begin
            w_state_next = EMIT;
          end
        end
      end
      EMIT: begin
        if (w_out_free) begin
          w_state_next      = FILL;
          w_flush_done_next = 1'b1;
        end
      end
      default: w_state_next = FILL;
    endcase
  end

  always_ff @(posedge rdclk) begin
    if (!rdrst_n) begin
      r_state      <= FILL;
      r_fill_cnt   <= '0;
      r_rd_pending <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_rd_pending <= rd_en;
      r_flush_done <= w_flush_done_next;
      if (w_load) begin
        r_fill_cnt <= '0;
      end else if (r_rd_pending) begin
        r_fill_cnt <= r_fill_cnt + FCW'(1);
      end
    end
  end

  assign flush_done = r_flush_done;

  fifo_out_reg #(
    .OUT_WIDTH  (OUT_WIDTH),
    .KEEP_WIDTH (BYTES_PER_WORD),
    .CNT_W      (WCNT_W)
  ) u_out_reg (
    .clk        (rdclk),
    .rst_n      (rdrst_n),
    .i_load     (w_load),
    .i_data     (w_load_data),
    .i_keep     (w_load_keep),
    .i_ready    (m_ready),
    .o_data     (m_data),
    .o_keep     (m_keep),
    .o_valid    (m_valid),
    .o_free     (w_out_free),
    .o_word_cnt (word_cnt)
  );
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a queue-based FIFO model feeds the DUT,
// directed tests push expected words, a monitor checks each accepted word.
module tb_fifo_rd_packer;
  localparam int DW  = 8;
  localparam int BPW = 4;
  localparam int OW  = DW * BPW;

  logic          rdclk = 1'b0;
  logic          rdrst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          flush = 1'b0;
  logic          m_ready = 1'b0;
  logic          rd_en;
  logic [OW-1:0] m_data;
  logic [BPW-1:0] m_keep;
  logic          m_valid;
  logic          flush_done;
  logic [15:0]   word_cnt;

  fifo_rd_packer #(
    .DATA_WIDTH     (DW),
    .BYTES_PER_WORD (BPW)
  ) dut (
    .rdclk      (rdclk),
    .rdrst_n    (rdrst_n),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .rd_en      (rd_en),
    .flush      (flush),
    .m_data     (m_data),
    .m_keep     (m_keep),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .flush_done (flush_done),
    .word_cnt   (word_cnt)
  );

  always #5 rdclk = ~rdclk;

  typedef struct packed {
    logic [OW-1:0]  data;
    logic [BPW-1:0] keep;
  } exp_t;

  logic [DW-1:0] fq [$];
  exp_t          sb [$];
  exp_t          mon_e;
  int n_checks = 0;
  int n_fail   = 0;
  logic guard_mode = 1'b0;
  logic toggle     = 1'b0;
  logic rd_latched = 1'b0;
  int rd_hi_cnt = 0, rd_run = 0, rd_run_max = 0, fd_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // FIFO read-side model: the entry popped by an rd_en edge appears before the next edge.
  always @(negedge rdclk) begin
    if (rd_latched) begin
      if (fq.size() > 0) fifo_rdata = fq.pop_front();
      else check("fifo_underflow", 64'd1, 64'd0);
    end
    toggle     = ~toggle;
    fifo_empty = (fq.size() == 0) || (guard_mode && toggle);
    #1;
    rd_latched = rd_en;
    if (rd_en) begin
      rd_hi_cnt++;
      rd_run++;
      if (rd_run > rd_run_max) rd_run_max = rd_run;
    end else begin
      rd_run = 0;
    end
    check("rd_en_guard", {62'd0, rd_en && fifo_empty, rd_en && !rdrst_n}, 64'd0);
  end

  // Monitor: a word valid with ready high at the negedge is accepted on the next posedge.
  always @(negedge rdclk) begin
    if (rdrst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", {32'd0, m_data}, 64'hDEAD_0000_0000);
      end else begin
        mon_e = sb.pop_front();
        $display("word accepted: data=0x%08h keep=%b (expected 0x%08h %b)", m_data, m_keep, mon_e.data, mon_e.keep);
        check("word_data", {32'd0, m_data}, {32'd0, mon_e.data});
        check("word_keep", {60'd0, m_keep}, {60'd0, mon_e.keep});
      end
    end
    if (flush_done) fd_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge rdclk);
    #2;
  endtask

  task automatic expect_word(input logic [OW-1:0] d, input logic [BPW-1:0] k);
    sb.push_back({d, k});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"},      {63'd0, rd_en},      64'd0);
    check({tag, "_m_valid"},    {63'd0, m_valid},    64'd0);
    check({tag, "_m_data"},     {32'd0, m_data},     64'd0);
    check({tag, "_m_keep"},     {60'd0, m_keep},     64'd0);
    check({tag, "_flush_done"}, {63'd0, flush_done}, 64'd0);
    check({tag, "_word_cnt"},   {48'd0, word_cnt},   64'd0);
  endtask

  logic [DW-1:0] seq_bytes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [DW-1:0] rb [8];
  int fd0;
  logic seen_fd, seen_valid;

  initial begin
    // Power-on reset
    rdrst_n = 1'b0;
    tick(3);
    @(negedge rdclk);
    check_reset_outputs("reset");
    tick(1);
    rdrst_n = 1'b1;
    tick(1);

    // Sequential fill
    m_ready = 1'b1;
    rd_hi_cnt = 0;
    rd_run_max = 0;
    for (int i = 0; i < 8; i++) fq.push_back(seq_bytes[i]);
    expect_word(32'h44332211, 4'b1111);
    expect_word(32'h88776655, 4'b1111);
    tick(15);
    check("seq_rd_cnt", 64'(rd_hi_cnt), 64'd8);
    check("seq_rd_run", 64'(rd_run_max), 64'd8);
    check("seq_word_cnt", {48'd0, word_cnt}, 64'd2);
    check("seq_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure: first word must hold, reads stop once the second word is packed
    m_ready = 1'b0;
    rd_hi_cnt = 0;
    for (int i = 0; i < 12; i++) fq.push_back(8'hA0 + 8'(i));
    expect_word(32'hA3A2A1A0, 4'b1111);
    expect_word(32'hA7A6A5A4, 4'b1111);
    expect_word(32'hABAAA9A8, 4'b1111);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (i >= 6) begin
        check("bp_hold_valid", {63'd0, m_valid}, 64'd1);
        check("bp_hold_data", {32'd0, m_data}, 64'hA3A2A1A0);
      end
    end
    check("bp_rd_stall", {63'd0, rd_en}, 64'd0);
    check("bp_rd_cnt", 64'(rd_hi_cnt), 64'd8);
    m_ready = 1'b1;
    tick(15);
    check("bp_word_cnt", {48'd0, word_cnt}, 64'd5);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Partial flush of three bytes
    fq.push_back(8'hA1);
    fq.push_back(8'hB2);
    fq.push_back(8'hC3);
    tick(8);
    expect_word(32'h00C3B2A1, 4'b0111);
    fd0 = fd_cnt;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(8);
    check("pf_flush_done", 64'(fd_cnt - fd0), 64'd1);
    check("pf_word_cnt", {48'd0, word_cnt}, 64'd6);
    check("pf_sb_empty", 64'(sb.size()), 64'd0);

    // Empty flush: flush_done only, within two cycles
    fd0 = fd_cnt;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    seen_fd = 1'b0;
    seen_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge rdclk);
      if (flush_done) seen_fd = 1'b1;
      if (m_valid) seen_valid = 1'b1;
    end
    check("ef_flush_done_seen", {63'd0, seen_fd}, 64'd1);
    check("ef_no_valid", {63'd0, seen_valid}, 64'd0);
    tick(3);
    check("ef_flush_done_cnt", 64'(fd_cnt - fd0), 64'd1);
    check("ef_word_cnt", {48'd0, word_cnt}, 64'd6);

    // Empty guard: fifo_empty toggles every cycle
    guard_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rb[i] = 8'($urandom_range(0, 255));
      fq.push_back(rb[i]);
    end
    expect_word({rb[3], rb[2], rb[1], rb[0]}, 4'b1111);
    expect_word({rb[7], rb[6], rb[5], rb[4]}, 4'b1111);
    tick(40);
    guard_mode = 1'b0;
    tick(2);
    check("eg_word_cnt", {48'd0, word_cnt}, 64'd8);
    check("eg_sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-word: two bytes captured, third in flight
    fq.push_back(8'hC1);
    fq.push_back(8'hC2);
    fq.push_back(8'hC3);
    tick(3);
    rdrst_n = 1'b0;
    tick(1);
    rdrst_n = 1'b1;
    @(negedge rdclk);
    check_reset_outputs("midrst");
    tick(1);
    fq.push_back(8'h5A);
    fq.push_back(8'h6B);
    fq.push_back(8'h7C);
    fq.push_back(8'h8D);
    expect_word(32'h8D7C6B5A, 4'b1111);
    tick(12);
    check("midrst_word_cnt", {48'd0, word_cnt}, 64'd1);
    check("midrst_sb_empty", 64'(sb.size()), 64'd0);
    check("fifo_drained", 64'(fq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
